// File: rtl/arb_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter.
package arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        I_DONE,
        D_DONE
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } arb_src_t;

endpackage

// File: rtl/cache_arbiter.sv
// Merges icache line fills and dcache fills/writebacks onto one memory port, one line at a time.
// Optional: define ARB_DCACHE_PRIO_EN for static dcache priority instead of round-robin.
module cache_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state_q, state_d;
    logic       i_req, d_req;
    logic       grant_i, grant_d;
    logic       capture_i, capture_d;

`ifndef ARB_DCACHE_PRIO_EN
    arb_src_t   last_grant;
`endif

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        capture_i   = 1'b0;
        capture_d   = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
`ifdef ARB_DCACHE_PRIO_EN
                    grant_d = 1'b1;
`else
                    if (last_grant == ICACHE) begin
                        grant_d = 1'b1;
                    end else begin
                        grant_i = 1'b1;
                    end
`endif
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) begin
                    state_d = I_BUSY;
                end else if (grant_d) begin
                    state_d = D_BUSY;
                end
            end
            I_BUSY: begin
                if (mem_resp) begin
                    capture_i = 1'b1;
                    state_d   = I_DONE;
                end
            end
            D_BUSY: begin
                if (mem_resp) begin
                    capture_d = 1'b1;
                    state_d   = D_DONE;
                end
            end
            // Response pulses decode straight from the state register, so they are glitch-free.
            I_DONE: begin
                i_pmem_resp = 1'b1;
                state_d     = IDLE;
            end
            D_DONE: begin
                d_pmem_resp = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read and write both high is illegal on the dcache side; write wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            i_pmem_rdata <= '0;
            d_pmem_rdata <= '0;
        end else begin
            if (grant_i) begin
                mem_read    <= 1'b1;
                mem_write   <= 1'b0;
                mem_address <= i_pmem_address;
            end else if (grant_d) begin
                mem_read    <= ~d_pmem_write;
                mem_write   <= d_pmem_write;
                mem_address <= d_pmem_address;
                mem_wdata   <= d_pmem_wdata;
            end
            if (capture_i || capture_d) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (capture_i) begin
                i_pmem_rdata <= mem_rdata;
            end
            if (capture_d && !mem_write) begin
                d_pmem_rdata <= mem_rdata;
            end
        end
    end

`ifndef ARB_DCACHE_PRIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= ICACHE;
        end else if (grant_i) begin
            last_grant <= ICACHE;
        end else if (grant_d) begin
            last_grant <= DCACHE;
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected memory transactions are queued as requests are raised.
module tb_cache_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    txn_t          exp_q[$];
    int            total;
    int            bad;
    int            cyc;
    int            resp_cyc;
    logic [LW-1:0] i_line_m;
    logic [LW-1:0] d_line_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_pmem_read && d_pmem_write))
        else $error("assertion: dcache read and write both high");
    a_i_hold: assert property (@(posedge clk) disable iff (!rst)
        (i_pmem_read && !i_pmem_resp) |=> i_pmem_read)
        else $error("assertion: icache strobe dropped before resp");
    a_d_hold: assert property (@(posedge clk) disable iff (!rst)
        ((d_pmem_read || d_pmem_write) && !d_pmem_resp) |=> (d_pmem_read || d_pmem_write))
        else $error("assertion: dcache strobe dropped before resp");

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic txn_t mk(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                                input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    // Serve one memory transaction with the given latency; drop: 0 none, 1 served side.
    task automatic run_mem(input int unsigned lat, input int unsigned drop);
        txn_t        e;
        int unsigned t;
        logic        held;
        t = 0;
        while (!(mem_read || mem_write) && t < 30) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (!(mem_read || mem_write) || exp_q.size() == 0) begin
            bad++;
            $display("FAIL grant: strobes read=%0b write=%0b queue=%0d, required one strobe and a queued txn",
                     mem_read, mem_write, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        total++;
        if ({mem_read, mem_write} !== {~e.wr, e.wr}) begin
            bad++;
            $display("FAIL mem_op: got rd/wr=%b%b required %b%b", mem_read, mem_write, ~e.wr, e.wr);
        end
        total++;
        if (mem_address !== e.addr) begin
            bad++;
            $display("FAIL mem_address: got %h required %h", mem_address, e.addr);
        end
        if (e.wr) begin
            total++;
            if (mem_wdata !== e.wdata) begin
                bad++;
                $display("FAIL mem_wdata: got %h required %h", mem_wdata, e.wdata);
            end
        end
        held = 1'b1;
        for (int unsigned k = 1; k < lat; k++) begin
            @(negedge clk);
            if ({mem_read, mem_write} !== {~e.wr, e.wr} || mem_address !== e.addr) held = 1'b0;
            if (i_pmem_resp || d_pmem_resp) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL strobe_hold: got stable=%b required 1 over %0d cycles", held, lat);
        end
        mem_rdata = e.rdata;
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = rand_line();
        resp_cyc  = cyc;
        if (!e.is_d) i_line_m = e.rdata;
        else if (!e.wr) d_line_m = e.rdata;
        total++;
        if ({i_pmem_resp, d_pmem_resp} !== {~e.is_d, e.is_d}) begin
            bad++;
            $display("FAIL resp: got i/d=%b%b required %b%b", i_pmem_resp, d_pmem_resp, ~e.is_d, e.is_d);
        end
        total++;
        if ({mem_read, mem_write} !== 2'b00) begin
            bad++;
            $display("FAIL strobe_drop: got rd/wr=%b%b required 00", mem_read, mem_write);
        end
        total++;
        if (i_pmem_rdata !== i_line_m) begin
            bad++;
            $display("FAIL i_rdata: got %h required %h", i_pmem_rdata, i_line_m);
        end
        total++;
        if (d_pmem_rdata !== d_line_m) begin
            bad++;
            $display("FAIL d_rdata: got %h required %h", d_pmem_rdata, d_line_m);
        end
        @(posedge clk);
        #1;
        if (drop == 1) begin
            if (e.is_d) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end else begin
                i_pmem_read = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            bad++;
            $display("FAIL resp_width: got i/d=%b%b required 00", i_pmem_resp, d_pmem_resp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got rd/wr/iresp/dresp=%b%b%b%b required 0000",
                     mem_read, mem_write, i_pmem_resp, d_pmem_resp);
        end
        total++;
        if (mem_address !== '0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h required zero", mem_address, mem_wdata);
        end
        total++;
        if (i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata: got i=%h d=%h required zero", i_pmem_rdata, d_pmem_rdata);
        end
        i_line_m = '0;
        d_line_m = '0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie;
        logic [LW-1:0] dl, il;
        dl = rand_line();
        il = rand_line();
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0040, '0, dl));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0100, '0, il));
        d_pmem_address = 32'h8000_0040;
        d_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0100;
        i_pmem_read    = 1'b1;
        run_mem(2, 1);
        run_mem(2, 1);
    endtask

    task automatic test_back_to_back;
        i_pmem_address = 32'h0000_0140;
        d_pmem_address = 32'h8000_0180;
`ifdef ARB_DCACHE_PRIO_EN
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0180, '0, rand_line()));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0180, '0, rand_line()));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0180, '0, rand_line()));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0140, '0, rand_line()));
`else
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0180, '0, rand_line()));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0140, '0, rand_line()));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0180, '0, rand_line()));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0140, '0, rand_line()));
`endif
        d_pmem_read = 1'b1;
        i_pmem_read = 1'b1;
        run_mem(1, 0);
        run_mem(2, 0);
        run_mem(1, 1);
        run_mem(2, 1);
    endtask

    task automatic test_icache_only;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0060, '0, {32{8'hA5}}));
        i_pmem_address = 32'h0000_0060;
        i_pmem_read    = 1'b1;
        run_mem(4, 1);
    endtask

    task automatic test_dcache_writeback;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h8000_0020, {16{16'h1234}}, rand_line()));
        d_pmem_address = 32'h8000_0020;
        d_pmem_wdata   = {16{16'h1234}};
        d_pmem_write   = 1'b1;
        run_mem(3, 1);
    endtask

    task automatic test_min_latency;
        int req_cyc;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_01C0, '0, rand_line()));
        i_pmem_address = 32'h0000_01C0;
        i_pmem_read    = 1'b1;
        req_cyc        = cyc;
        run_mem(1, 1);
        // Resp visible two edges after the request, so the cache samples it on the third edge.
        total++;
        if (resp_cyc - req_cyc !== 2) begin
            bad++;
            $display("FAIL min_latency: got %0d edges to resp required 2", resp_cyc - req_cyc);
        end
    endtask

    task automatic test_spurious_resp;
        @(negedge clk);
        mem_rdata = rand_line();
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        total++;
        if ({i_pmem_resp, d_pmem_resp, mem_read, mem_write} !== 4'b0000) begin
            bad++;
            $display("FAIL spurious_ctrl: got iresp/dresp/rd/wr=%b%b%b%b required 0000",
                     i_pmem_resp, d_pmem_resp, mem_read, mem_write);
        end
        total++;
        if (i_pmem_rdata !== i_line_m || d_pmem_rdata !== d_line_m) begin
            bad++;
            $display("FAIL spurious_rdata: got i=%h d=%h required i=%h d=%h",
                     i_pmem_rdata, d_pmem_rdata, i_line_m, d_line_m);
        end
        @(negedge clk);
        total++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            bad++;
            $display("FAIL spurious_resp_late: got i/d=%b%b required 00", i_pmem_resp, d_pmem_resp);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0200, '0, rand_line()));
        i_pmem_address = 32'h0000_0200;
        i_pmem_read    = 1'b1;
        run_mem(2, 1);
    endtask

    task automatic test_reset_mid;
        logic seen;
        d_pmem_address = 32'h8000_0100;
        d_pmem_wdata   = rand_line();
        d_pmem_write   = 1'b1;
        @(negedge clk);
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL mid_write_up: got mem_write=%b required 1", mem_write);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({mem_read, mem_write} !== 2'b00) begin
            bad++;
            $display("FAIL mid_async_drop: got rd/wr=%b%b required 00", mem_read, mem_write);
        end
        d_pmem_write = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (i_pmem_resp || d_pmem_resp) seen = 1'b1;
        end
        i_line_m = '0;
        d_line_m = '0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (i_pmem_resp || d_pmem_resp) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_resp: got resp seen=%b required 0", seen);
        end
        total++;
        if (i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            bad++;
            $display("FAIL mid_rdata_clear: got i=%h d=%h required zero", i_pmem_rdata, d_pmem_rdata);
        end
        test_tie();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        cyc            = 0;
        resp_cyc       = 0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_rdata      = '0;
        mem_resp       = 1'b0;
        i_line_m       = '0;
        d_line_m       = '0;
        test_reset();
        test_tie();
        test_back_to_back();
        test_icache_only();
        test_dcache_writeback();
        test_min_latency();
        test_spurious_resp();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
